// File: rtl/regfile_read_arbiter_if.sv
// Request/response bundle between the requesters, the register-file read mux and the read-port arbiter.
// The slave modport is the arbiter's side; the master modport is the requesters, mux and response consumer.
interface regfile_read_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]              req_valid;
    logic [NREQ-1:0][ADDR_W-1:0]  req_addr;
    logic [NREQ-1:0]              req_ready;
    logic [ADDR_W-1:0]            read_reg;
    logic [DATA_W-1:0]            read_data;
    logic                         rsp_valid;
    logic [ID_W-1:0]              rsp_id;
    logic [DATA_W-1:0]            rsp_data;
    logic                         rsp_ready;
    logic                         busy;

    modport slave (
        input  req_valid, req_addr, read_data, rsp_ready,
        output req_ready, read_reg, rsp_valid, rsp_id, rsp_data, busy
    );

    modport master (
        output req_valid, req_addr, read_data, rsp_ready,
        input  req_ready, read_reg, rsp_valid, rsp_id, rsp_data, busy
    );
endinterface

// File: rtl/regfile_read_arbiter.sv
// Round-robin share of the register-file read port: grant at N, read_reg at N+1, tagged response at N+2; no grant while the response is stalled.
// REGFILE_ZERO_BYPASS_EN: a grant to x31 skips the mux fetch and responds with zero at N+1, leaving read_reg untouched.
module regfile_read_arbiter #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    regfile_read_arbiter_if.slave bus
);
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_RESP} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    r_fetch_id;
    logic [ID_W-1:0]    r_rsp_id;
    logic [ADDR_W-1:0]  r_read_reg;
    logic [DATA_W-1:0]  r_rsp_data;
    logic               r_rsp_valid;

    logic               w_any;
    logic [ID_W-1:0]    w_win_id;
    logic [ADDR_W-1:0]  w_win_addr;
    logic               w_slot_free;
    logic               w_grant;
    logic               w_bypass;
    logic               w_capture;
    logic [NREQ-1:0]    w_req_ready;
    int                 w_idx;

    // Search starts at the round-robin pointer and wraps; the first valid requester wins.
    always_comb begin
        w_any    = 1'b0;
        w_win_id = '0;
        w_idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (!w_any && bus.req_valid[w_idx]) begin
                w_any    = 1'b1;
                w_win_id = ID_W'(w_idx);
            end
        end
    end

    assign w_slot_free = !r_rsp_valid || bus.rsp_ready;
    assign w_grant     = !i_reset && (r_state != S_FETCH) && w_slot_free && w_any;
    assign w_win_addr  = bus.req_addr[w_win_id];

`ifdef REGFILE_ZERO_BYPASS_EN
    assign w_bypass = w_grant && (w_win_addr == ADDR_W'(31));
`else
    assign w_bypass = 1'b0;
`endif

    always_comb begin
        w_req_ready = '0;
        if (w_grant) begin
            w_req_ready[w_win_id] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = w_bypass ? S_RESP : S_FETCH;
                end
            end
            S_FETCH: begin
                w_capture   = 1'b1;
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (w_grant) begin
                    w_state_nxt = w_bypass ? S_RESP : S_FETCH;
                end else if (bus.rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rr_ptr    <= '0;
            r_fetch_id  <= '0;
            r_read_reg  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
        end else begin
            if (w_grant) begin
                r_rr_ptr <= (w_win_id == ID_W'(NREQ - 1)) ? '0 : w_win_id + 1'b1;
            end
            if (w_grant && !w_bypass) begin
                r_read_reg <= w_win_addr;
                r_fetch_id <= w_win_id;
            end
            // A grant out of RESP retires the old response; valid stays low until the new capture.
            if (w_capture) begin
                r_rsp_valid <= 1'b1;
                r_rsp_id    <= r_fetch_id;
                r_rsp_data  <= bus.read_data;
            end else if (w_bypass) begin
                r_rsp_valid <= 1'b1;
                r_rsp_id    <= w_win_id;
                r_rsp_data  <= '0;
            end else if (w_grant || bus.rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.read_reg  = r_read_reg;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.busy      = r_rsp_valid || (|bus.req_valid);
endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Bench for regfile_read_arbiter: vector table, corner-case sequences, then random traffic against a cycle model.
module tb_regfile_read_arbiter;
    localparam int NREQ   = 4;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    regfile_read_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_read_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    // Register-file contents as seen through the mux; x31 reads as zero.
    function automatic logic [63:0] mem(input logic [4:0] a);
        if (a == 5'd31) return 64'd0;
        if (a == 5'd5)  return 64'h0123_4567_89AB_CDEF;
        return 64'hC0DE_0000_0000_0000 | ({59'd0, a} * 64'h0000_0101_0101_0101);
    endfunction

    assign bus.read_data = mem(bus.read_reg);

    typedef struct {
        logic [3:0]      mask;
        logic [3:0][4:0] addr;
        logic [3:0]      exp_ready;
        logic [4:0]      exp_reg;
        logic [1:0]      exp_id;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hard_reset();
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int         m_rr;
        int         w;
        bit         m_rv;
        bit         m_fetch;
        logic [1:0] m_id;
        logic [1:0] m_fid;
        logic [4:0] m_faddr;
        logic [63:0] m_data;
        logic [3:0] exp_ready;
        int         prev;

        tbl[0] = '{4'b0001, {5'd0,  5'd0,  5'd0,  5'd5}, 4'b0001, 5'd5,  2'd0};
        tbl[1] = '{4'b0001, {5'd0,  5'd0,  5'd0,  5'd7}, 4'b0001, 5'd7,  2'd0};
        tbl[2] = '{4'b1111, {5'd12, 5'd11, 5'd10, 5'd9}, 4'b0010, 5'd10, 2'd1};
        tbl[3] = '{4'b0011, {5'd12, 5'd11, 5'd10, 5'd9}, 4'b0001, 5'd9,  2'd0};
        tbl[4] = '{4'b1100, {5'd12, 5'd11, 5'd10, 5'd9}, 4'b0100, 5'd11, 2'd2};
        tbl[5] = '{4'b0101, {5'd12, 5'd11, 5'd10, 5'd9}, 4'b0001, 5'd9,  2'd0};
        tbl[6] = '{4'b1000, {5'd12, 5'd11, 5'd10, 5'd9}, 4'b1000, 5'd12, 2'd3};
        tbl[7] = '{4'b1010, {5'd20, 5'd0,  5'd30, 5'd0}, 4'b0010, 5'd30, 2'd1};

        // Reset state, with every requester asserting during reset.
        bus.req_valid = 4'hF;
        bus.req_addr  = {5'd3, 5'd2, 5'd1, 5'd4};
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_id",    64'(bus.rsp_id),    64'd0);
        chk("rst_rsp_data",  bus.rsp_data,       64'd0);
        chk("rst_read_reg",  64'(bus.read_reg),  64'd0);
        chk("rst_busy",      64'(bus.busy),      64'd1);
        bus.req_valid = '0;
        reset = 1'b0;
        #1;
        chk("idle_busy", 64'(bus.busy), 64'd0);

        // Vector table: isolated reads from IDLE with an evolving round-robin pointer.
        for (int i = 0; i < 8; i++) begin
            bus.req_valid = tbl[i].mask;
            bus.req_addr  = tbl[i].addr;
            bus.rsp_ready = 1'b0;
            #1;
            chk($sformatf("tbl%0d_ready", i), 64'(bus.req_ready), 64'(tbl[i].exp_ready));
            tick();
            bus.req_valid = '0;
            #1;
            chk($sformatf("tbl%0d_read_reg", i), 64'(bus.read_reg), 64'(tbl[i].exp_reg));
            chk($sformatf("tbl%0d_fetch_vld", i), 64'(bus.rsp_valid), 64'd0);
            tick();
            chk($sformatf("tbl%0d_rsp_vld", i), 64'(bus.rsp_valid), 64'd1);
            chk($sformatf("tbl%0d_rsp_id", i), 64'(bus.rsp_id), 64'(tbl[i].exp_id));
            chk($sformatf("tbl%0d_rsp_data", i), bus.rsp_data, mem(tbl[i].exp_reg));
            bus.rsp_ready = 1'b1;
            tick();
            bus.rsp_ready = 1'b0;
            #1;
            chk($sformatf("tbl%0d_retired", i), 64'(bus.rsp_valid), 64'd0);
        end

        // Fairness: all four requesting, one grant every two cycles, order 0,1,2,3,0.
        hard_reset();
        bus.req_valid = 4'hF;
        bus.req_addr  = {5'd4, 5'd3, 5'd2, 5'd1};
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (k % 2 == 0) begin
                chk($sformatf("fair%0d_ready", k), 64'(bus.req_ready), 64'(4'b0001 << ((k / 2) % 4)));
            end else begin
                chk($sformatf("fair%0d_ready", k), 64'(bus.req_ready), 64'd0);
                chk($sformatf("fair%0d_vld", k), 64'(bus.rsp_valid), 64'd0);
            end
            if (k % 2 == 0 && k >= 2) begin
                prev = (k / 2 - 1) % 4;
                chk($sformatf("fair%0d_vld", k), 64'(bus.rsp_valid), 64'd1);
                chk($sformatf("fair%0d_id", k), 64'(bus.rsp_id), 64'(prev));
                chk($sformatf("fair%0d_data", k), bus.rsp_data, mem(5'(prev + 1)));
            end
            tick();
        end
        bus.req_valid = '0;
        tick();
        tick();
        tick();

        // Backpressure: response stalled five cycles while requester 1 waits.
        hard_reset();
        bus.req_valid = 4'b0001;
        bus.req_addr  = {5'd0, 5'd0, 5'd8, 5'd6};
        #1;
        chk("bp_first_ready", 64'(bus.req_ready), 64'b0001);
        tick();
        bus.req_valid = 4'b0010;
        #1;
        chk("bp_fetch_ready", 64'(bus.req_ready), 64'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d_ready", i), 64'(bus.req_ready), 64'd0);
            chk($sformatf("bp%0d_vld", i), 64'(bus.rsp_valid), 64'd1);
            chk($sformatf("bp%0d_id", i), 64'(bus.rsp_id), 64'd0);
            chk($sformatf("bp%0d_data", i), bus.rsp_data, mem(5'd6));
            tick();
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(bus.req_ready), 64'b0010);
        tick();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        #1;
        chk("bp_refetch_vld", 64'(bus.rsp_valid), 64'd0);
        chk("bp_refetch_reg", 64'(bus.read_reg), 64'd8);
        tick();
        chk("bp_rsp_id", 64'(bus.rsp_id), 64'd1);
        chk("bp_rsp_data", bus.rsp_data, mem(5'd8));
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;

        // x31 read issued back-to-back after a read of x9.
        hard_reset();
        bus.req_valid = 4'b0001;
        bus.req_addr  = {5'd0, 5'd0, 5'd0, 5'd9};
        tick();
        bus.req_valid = '0;
        tick();
        bus.req_valid = 4'b0001;
        bus.req_addr  = {5'd0, 5'd0, 5'd0, 5'd31};
        bus.rsp_ready = 1'b1;
        #1;
        chk("x31_ready", 64'(bus.req_ready), 64'b0001);
        tick();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        #1;
`ifdef REGFILE_ZERO_BYPASS_EN
        chk("x31_byp_vld",  64'(bus.rsp_valid), 64'd1);
        chk("x31_byp_data", bus.rsp_data,       64'd0);
        chk("x31_byp_reg",  64'(bus.read_reg),  64'd9);
`else
        chk("x31_fetch_vld", 64'(bus.rsp_valid), 64'd0);
        chk("x31_fetch_reg", 64'(bus.read_reg),  64'd31);
        tick();
        chk("x31_vld",  64'(bus.rsp_valid), 64'd1);
        chk("x31_data", bus.rsp_data,       64'd0);
`endif
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;

        // Reset while a stalled response is held; pointer returns to 0.
        hard_reset();
        bus.req_valid = 4'b0010;
        bus.req_addr  = {5'd0, 5'd13, 5'd5, 5'd3};
        tick();
        bus.req_valid = '0;
        tick();
        chk("mid_rsp_vld", 64'(bus.rsp_valid), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_vld",   64'(bus.rsp_valid), 64'd0);
        chk("mid_rst_ready", 64'(bus.req_ready), 64'd0);
        chk("mid_rst_data",  bus.rsp_data,       64'd0);
        bus.req_valid = 4'b0101;
        #1;
        chk("mid_rst_rr", 64'(bus.req_ready), 64'b0001);
        bus.req_valid = 4'b0100;
        #1;
        chk("mid_rst_req2", 64'(bus.req_ready), 64'b0100);
        tick();
        bus.req_valid = '0;
        #1;
        chk("mid_rst_reg", 64'(bus.read_reg), 64'd13);
        tick();
        chk("mid_rst_id",   64'(bus.rsp_id), 64'd2);
        chk("mid_rst_rdat", bus.rsp_data,    mem(5'd13));
        bus.rsp_ready = 1'b1;
        tick();

        // Random traffic against a transaction-level model.
        hard_reset();
        m_rr = 0; m_rv = 0; m_fetch = 0; m_id = '0; m_fid = '0; m_faddr = '0; m_data = '0;
        for (int c = 0; c < 500; c++) begin
            bus.req_valid = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) begin
                bus.req_addr[i] = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            w = -1;
            if (!m_fetch && (!m_rv || bus.rsp_ready)) begin
                for (int k = 0; k < 4; k++) begin
                    if (w < 0 && bus.req_valid[(m_rr + k) % 4]) w = (m_rr + k) % 4;
                end
            end
            exp_ready = (w >= 0) ? 4'(1 << w) : 4'd0;
            chk($sformatf("rnd%0d_ready", c), 64'(bus.req_ready), 64'(exp_ready));
            chk($sformatf("rnd%0d_vld", c), 64'(bus.rsp_valid), 64'(m_rv));
            chk($sformatf("rnd%0d_busy", c), 64'(bus.busy), 64'(m_rv || (|bus.req_valid)));
            if (m_rv) begin
                chk($sformatf("rnd%0d_id", c), 64'(bus.rsp_id), 64'(m_id));
                chk($sformatf("rnd%0d_data", c), bus.rsp_data, m_data);
            end
            if (m_fetch) begin
                chk($sformatf("rnd%0d_reg", c), 64'(bus.read_reg), 64'(m_faddr));
            end
            if (m_fetch) begin
                m_rv = 1; m_id = m_fid; m_data = mem(m_faddr); m_fetch = 0;
            end else if (w >= 0) begin
                m_rr = (w + 1) % 4;
`ifdef REGFILE_ZERO_BYPASS_EN
                if (bus.req_addr[w] == 5'd31) begin
                    m_rv = 1; m_id = 2'(w); m_data = 64'd0;
                end else begin
                    m_rv = 0; m_fetch = 1; m_fid = 2'(w); m_faddr = bus.req_addr[w];
                end
`else
                m_rv = 0; m_fetch = 1; m_fid = 2'(w); m_faddr = bus.req_addr[w];
`endif
            end else if (m_rv && bus.rsp_ready) begin
                m_rv = 0;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
